// File: rtl/alu_ctrl_pkg.sv
// Shared ALU operation codes, ALUOp encoding, M-extension funct7 and FSM state
// encoding for the ALU / multiply-divide control block.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [2:0] {
    ALUOP_R      = 3'b000,
    ALUOP_BRANCH = 3'b001,
    ALUOP_MEM    = 3'b010,
    ALUOP_IALU   = 3'b011,
    ALUOP_UPPER  = 3'b100
  } aluop_e;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_MD_WAIT = 1'b1;

  // Base (funct7=0) funct3 mapping shared by R-type and I-ALU decode.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7 decode to ALU code, illegal flag and M-op flag.
// M-extension ops are recognised only when RV32M_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_c_o,
  output logic       illegal_c_o,
  output logic       is_m_c_o
);

  always_comb begin
    alu_c_o     = ALU_ADD;
    illegal_c_o = 1'b0;
    is_m_c_o    = 1'b0;
    case (aluop_i)
      ALUOP_R: begin
        if (funct7_i == FUNCT7_BASE) begin
          alu_c_o = base_alu(funct3_i);
        end else if (funct7_i == FUNCT7_ALT) begin
          if (funct3_i == 3'b000)      alu_c_o = ALU_SUB;
          else if (funct3_i == 3'b101) alu_c_o = ALU_SRA;
          else                         illegal_c_o = 1'b1;
`ifdef RV32M_EN
        end else if (funct7_i == FUNCT7_M) begin
          is_m_c_o = 1'b1;
`endif
        end else begin
          illegal_c_o = 1'b1;
        end
      end
      ALUOP_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   alu_c_o = ALU_SUB;
          2'b10:   alu_c_o = ALU_SLT;
          2'b11:   alu_c_o = ALU_SLTU;
          default: illegal_c_o = 1'b1;
        endcase
      end
      ALUOP_MEM, ALUOP_UPPER: alu_c_o = ALU_ADD;
      ALUOP_IALU: begin
        if (funct3_i == 3'b101) alu_c_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
        else                    alu_c_o = base_alu(funct3_i);
      end
      default: illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mdu_control.sv
// ALU control with registered outputs and a multi-cycle multiply/divide sequencer.
// Define RV32M_EN to enable M-extension ops and the MD_WAIT state.
module alu_mdu_control
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              flush,
  input  logic [2:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ALU_control,
  output logic [2:0]        md_op,
  output logic              md_start,
  output logic              stall,
  output logic              illegal
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
`ifdef RV32M_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  logic [3:0]        dec_alu_c;
  logic              dec_illegal_c;
  logic              dec_is_m_c;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              md_start_q, md_start_d;
  logic              stall_q, stall_d;
  logic              illegal_q, illegal_d;
  logic [CTRL_W-1:0] alu_q, alu_d;
  logic [2:0]        md_op_q, md_op_d;
  logic [2:0]        pend_q, pend_d;

  alu_ctrl_decode u_decode (
    .aluop_i     (ALUOp),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .alu_c_o     (dec_alu_c),
    .illegal_c_o (dec_illegal_c),
    .is_m_c_o    (dec_is_m_c)
  );

  // Next-state: flush overrides everything, including a same-cycle request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    md_start_d = 1'b0;
    stall_d    = stall_q;
    illegal_d  = illegal_q;
    alu_d      = alu_q;
    md_op_d    = md_op_q;
    pend_d     = pend_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      stall_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            if (dec_is_m_c) begin
              state_d    = ST_MD_WAIT;
              md_start_d = 1'b1;
              stall_d    = 1'b1;
              pend_d     = funct3;
              cnt_d      = funct3[2] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else begin
              valid_d   = 1'b1;
              alu_d     = CTRL_W'(dec_alu_c);
              illegal_d = dec_illegal_c;
              md_op_d   = 3'b000;
            end
          end
        end
        ST_MD_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            valid_d   = 1'b1;
            stall_d   = 1'b0;
            alu_d     = CTRL_W'(ALU_ADD);
            illegal_d = 1'b0;
            md_op_d   = pend_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      md_start_q <= 1'b0;
      stall_q    <= 1'b0;
      illegal_q  <= 1'b0;
      alu_q      <= CTRL_W'(ALU_ADD);
      md_op_q    <= 3'b000;
      pend_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      md_start_q <= md_start_d;
      stall_q    <= stall_d;
      illegal_q  <= illegal_d;
      alu_q      <= alu_d;
      md_op_q    <= md_op_d;
      pend_q     <= pend_d;
    end
  end

  // Without the M extension the sequencer outputs fold to constants.
  assign ready_out   = (state_q == ST_IDLE) || !M_EN;
  assign md_start    = md_start_q && M_EN;
  assign stall       = stall_q && M_EN;
  assign md_op       = md_op_q & {3{M_EN}};
  assign valid_out   = valid_q;
  assign ALU_control = alu_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Self-checking bench for alu_mdu_control; adapts to builds with or without RV32M_EN.
module tb_alu_mdu_control;

  localparam int unsigned MUL_C = 1;
  localparam int unsigned DIV_C = 32;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       valid_in = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] ALUOp = 3'b000;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic       ready_out, valid_out, md_start, stall, illegal;
  logic [3:0] ALU_control;
  logic [2:0] md_op;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] alu;
    logic       ill;
    logic [2:0] op;
    logic [7:0] lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  alu_mdu_control #(.CTRL_W(4), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .CLK(CLK), .RST_N(RST_N), .valid_in(valid_in), .ready_out(ready_out),
    .flush(flush), .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7),
    .valid_out(valid_out), .ALU_control(ALU_control), .md_op(md_op),
    .md_start(md_start), .stall(stall), .illegal(illegal)
  );

  function automatic exp_t model(input logic [2:0] a, input logic [2:0] f3, input logic [6:0] f7);
    exp_t e;
    e = '0;
    case (a)
      3'd0: begin
        if (f7 == 7'h00) e.alu = {1'b0, f3};
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'b1000;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'b1101;
        else if (f7 == 7'h01 && M_EN) begin
          e.op  = f3;
          e.lat = f3[2] ? 8'(DIV_C) : 8'(MUL_C);
        end else e.ill = 1'b1;
      end
      3'd1: begin
        if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
        else if (f3 < 3'd2) e.alu = 4'b1000;
        else e.alu = f3[1] ? 4'b0011 : 4'b0010;
      end
      3'd2, 3'd4: e.alu = 4'b0000;
      3'd3: e.alu = (f3 == 3'd5) ? {f7[5], 3'b101} : {1'b0, f3};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Present one request (caller sits just after a clock edge with the DUT idle).
  task automatic send(input logic [2:0] a, input logic [2:0] f3, input logic [6:0] f7);
    valid_in = 1'b1; ALUOp = a; funct3 = f3; funct7 = f7;
    sb_q.push_back(model(a, f3, f7));
    @(posedge CLK); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    while (!ok && lat < int'(DIV_C) + 8) begin
      if (valid_out === 1'b1) ok = 1'b1;
      else begin @(posedge CLK); #1; lat++; end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; #1; RST_N = 1'b0; #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_out); end
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL rst_md_start got %b want 0", md_start); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", illegal); end
    checks++; if (ALU_control !== 4'b0000) begin errors++; $display("FAIL rst_alu got %b want 0000", ALU_control); end
    checks++; if (md_op !== 3'b000) begin errors++; $display("FAIL rst_md_op got %b want 000", md_op); end
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready_out); end
  endtask

  task automatic test_sra();
    bit ok; int lat; exp_t e;
    send(3'b000, 3'b101, 7'h20);
    wait_valid(ok, lat);
    e = sb_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL sra_timeout got no valid_out want pulse"); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL sra_latency got %0d want 0", lat); end
    checks++; if (ALU_control !== e.alu) begin errors++; $display("FAIL sra_alu got %b want %b", ALU_control, e.alu); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL sra_illegal got %b want 0", illegal); end
  endtask

  task automatic test_sweep();
    bit ok; int lat; exp_t e;
    logic [6:0] f7s [3];
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;
    for (int a = 0; a < 8; a++) begin
      for (int f = 0; f < 8; f++) begin
        for (int k = 0; k < 3; k++) begin
          send(3'(a), 3'(f), f7s[k]);
          wait_valid(ok, lat);
          e = sb_q.pop_front();
          checks++;
          if (!ok) begin
            errors++; $display("FAIL sweep_timeout op=%0d f3=%0d f7=%h got no valid_out", a, f, f7s[k]);
          end else begin
            if (ALU_control !== e.alu || illegal !== e.ill || md_op !== e.op || lat != int'(e.lat)) begin
              errors++;
              $display("FAIL sweep op=%0d f3=%0d f7=%h got alu=%b ill=%b md_op=%b lat=%0d want alu=%b ill=%b md_op=%b lat=%0d",
                       a, f, f7s[k], ALU_control, illegal, md_op, lat, e.alu, e.ill, e.op, e.lat);
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0] a, f3;
    logic [6:0] f7;
    for (int i = 0; i < 8; i++) begin
      a  = 3'($urandom_range(0, 5));
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      valid_in = 1'b1; ALUOp = a; funct3 = f3; funct7 = f7;
      sb_q.push_back(model(a, f3, f7));
      @(posedge CLK); #1;
      e = sb_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || ALU_control !== e.alu || illegal !== e.ill) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b alu=%b ill=%b want v=1 alu=%b ill=%b", i, valid_out, ALU_control, illegal, e.alu, e.ill);
      end
    end
    valid_in = 1'b0;
    @(posedge CLK); #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_tail got %b want 0", valid_out); end
  endtask

  task automatic test_flush_idle();
    bit ok; int lat; exp_t e;
    send(3'b010, 3'b111, 7'h20);
    wait_valid(ok, lat);
    e = sb_q.pop_front();
    checks++; if (!ok || ALU_control !== e.alu) begin errors++; $display("FAIL fl_pre got alu=%b want %b", ALU_control, e.alu); end
    valid_in = 1'b1; flush = 1'b1; ALUOp = 3'b011; funct3 = 3'b101; funct7 = 7'h20;
    @(posedge CLK); #1;
    valid_in = 1'b0; flush = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fl_valid got %b want 0", valid_out); end
    checks++; if (ALU_control !== 4'b0000) begin errors++; $display("FAIL fl_hold_alu got %b want 0000", ALU_control); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL fl_ready got %b want 1", ready_out); end
  endtask

  task automatic test_m_disabled();
    exp_t e;
    valid_in = 1'b1; ALUOp = 3'b000; funct3 = 3'b000; funct7 = 7'h01;
    sb_q.push_back(model(3'b000, 3'b000, 7'h01));
    @(posedge CLK); #1;
    valid_in = 1'b0;
    e = sb_q.pop_front();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL nom_valid got %b want 1", valid_out); end
    checks++; if (illegal !== e.ill) begin errors++; $display("FAIL nom_illegal got %b want %b", illegal, e.ill); end
    checks++; if (md_start !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL nom_md got start=%b stall=%b want 0 0", md_start, stall); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL nom_ready got %b want 1", ready_out); end
    @(posedge CLK); #1;
    checks++; if (md_start !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL nom_after got start=%b v=%b want 0 0", md_start, valid_out); end
  endtask

`ifdef RV32M_EN
  task automatic test_div();
    exp_t e;
    int lat = 0, stall_n = 0, start_n = 0, rdy_n = 0;
    valid_in = 1'b1; ALUOp = 3'b000; funct3 = 3'b100; funct7 = 7'h01;
    sb_q.push_back(model(3'b000, 3'b100, 7'h01));
    @(posedge CLK); #1;
    valid_in = 1'b0;
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL div_start got %b want 1", md_start); end
    while (valid_out !== 1'b1 && lat < 60) begin
      if (stall === 1'b1) stall_n++;
      if (md_start === 1'b1) start_n++;
      if (ready_out !== 1'b0) rdy_n++;
      @(posedge CLK); #1; lat++;
    end
    e = sb_q.pop_front();
    checks++; if (lat != int'(e.lat)) begin errors++; $display("FAIL div_latency got %0d want %0d", lat, e.lat); end
    checks++; if (stall_n != 32) begin errors++; $display("FAIL div_stall_cycles got %0d want 32", stall_n); end
    checks++; if (start_n != 1) begin errors++; $display("FAIL div_start_cycles got %0d want 1", start_n); end
    checks++; if (rdy_n != 0) begin errors++; $display("FAIL div_ready_high got %0d want 0", rdy_n); end
    checks++; if (md_op !== e.op || ALU_control !== e.alu) begin errors++; $display("FAIL div_result got op=%b alu=%b want op=%b alu=%b", md_op, ALU_control, e.op, e.alu); end
    checks++; if (stall !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL div_done got stall=%b rdy=%b want 0 1", stall, ready_out); end
    @(posedge CLK); #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL div_pulse got %b want 0", valid_out); end
  endtask

  task automatic test_flush_div();
    int seen = 0;
    valid_in = 1'b1; ALUOp = 3'b000; funct3 = 3'b101; funct7 = 7'h01;
    @(posedge CLK); #1;
    valid_in = 1'b0;
    repeat (22) @(posedge CLK);
    #1;
    flush = 1'b1; valid_in = 1'b1; ALUOp = 3'b010; funct3 = 3'b000; funct7 = 7'h00;
    @(posedge CLK); #1;
    flush = 1'b0; valid_in = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fdiv_valid got %b want 0", valid_out); end
    checks++; if (ready_out !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL fdiv_idle got rdy=%b stall=%b want 1 0", ready_out, stall); end
    repeat (40) begin
      @(posedge CLK); #1;
      if (valid_out === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL fdiv_late_valid got %0d want 0", seen); end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok; int lat; int seen = 0; exp_t e;
    send(3'b011, 3'b101, 7'h20);
    wait_valid(ok, lat);
    e = sb_q.pop_front();
    checks++; if (!ok || ALU_control !== e.alu) begin errors++; $display("FAIL rmid_pre got alu=%b want %b", ALU_control, e.alu); end
    if (M_EN) begin
      valid_in = 1'b1; ALUOp = 3'b000; funct3 = 3'b110; funct7 = 7'h01;
      @(posedge CLK); #1;
      valid_in = 1'b0;
      repeat (5) @(posedge CLK);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_busy got stall=%b want 1", stall); end
    end
    #2 RST_N = 1'b0; #1;
    checks++; if (valid_out !== 1'b0 || md_start !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmid_ctl got v=%b st=%b stall=%b want 0 0 0", valid_out, md_start, stall); end
    checks++; if (ALU_control !== 4'b0000 || md_op !== 3'b000 || illegal !== 1'b0) begin errors++; $display("FAIL rmid_data got alu=%b op=%b ill=%b want 0000 000 0", ALU_control, md_op, illegal); end
    @(posedge CLK); #2 RST_N = 1'b1;
    repeat (40) begin
      @(posedge CLK); #1;
      if (valid_out === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_late_valid got %0d want 0", seen); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", ready_out); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sra();
    test_sweep();
    test_back_to_back();
    test_flush_idle();
`ifdef RV32M_EN
    test_div();
    test_flush_div();
`else
    test_m_disabled();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
